// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and helpers for the UART transmit arbiter slice.
//   - BYTE_W / byte_t : width and type of one transmitted byte
//   - arb_state_e     : arbiter FSM states
//   - WAIT_BUSY_LIMIT : cycles the arbiter waits for tx_busy before giving up
//   - bit_cycles()    : clock cycles per UART bit time
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT_BUSY,
        ST_SEND,
        ST_GAP
    } arb_state_e;

    // If the transmitter never raises tx_busy within this many cycles after
    // tx_start, the arbiter treats the frame as lost and moves on.
    localparam int unsigned WAIT_BUSY_LIMIT = 4;

    function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                               input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational round-robin selector. The search starts at last_idx+1
//   (modulo NUM_REQ) and returns the first index whose request bit is set.
//   Ports:
//     req      in   NUM_REQ          request vector
//     last_idx in   clog2(NUM_REQ)   index granted most recently
//     winner   out  clog2(NUM_REQ)   selected index (last_idx when none found)
//     found    out  1                at least one request bit was set
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       found
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = last_idx;
        found  = 1'b0;
        cand   = '0;
        // Offsets 1..NUM_REQ visit every index once, ending on last_idx
        // itself so a lone requester can be granted repeatedly.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(last_idx) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ byte producers share one UART
//   transmitter. Each accepted byte is handed to the transmitter with a
//   one-cycle tx_start pulse; after the frame completes (or the transmitter
//   fails to respond) an idle gap of GAP_BITS bit-times is enforced before
//   the next grant.
//
//   Optional feature (macro UART_ARB_LOCK_EN): adds input req_last. A byte
//   granted with req_last[i]=0 locks the arbiter onto requester i until a
//   byte from i is granted with req_last[i]=1.
//
//   Ports:
//     clock      in   1                 system clock, rising edge
//     reset      in   1                 synchronous, active-high
//     req_valid  in   NUM_REQ           requester i has a byte pending
//     req_data   in   NUM_REQ x 8       byte of requester i
//     req_last   in   NUM_REQ           last byte of a locked burst (macro only)
//     req_ready  out  NUM_REQ           one-cycle accept pulse to requester i
//     tx_start   out  1                 one-cycle start pulse to the transmitter
//     tx_data    out  8                 byte to transmit, stable through frame
//     tx_busy    in   1                 transmitter frame in progress
//     grant_id   out  clog2(NUM_REQ)    index of the last granted requester
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CLK_FREQ = 4_992_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned GAP_BITS = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  byte_t [NUM_REQ-1:0]        req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_last,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output byte_t                      tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned BIT_CYC  = bit_cycles(CLK_FREQ, BAUD);
    localparam int unsigned GAP_CYC  = GAP_BITS * BIT_CYC;
    // A zero-length gap still spends one cycle in ST_GAP.
    localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
    localparam int unsigned GAP_W    = (GAP_LAST < 2) ? 1 : $clog2(GAP_LAST + 1);
    localparam logic [IDX_W-1:0] ID_RESET = IDX_W'(NUM_REQ - 1);

    arb_state_e        state_q,    state_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    byte_t             tx_data_q,  tx_data_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;

    logic [NUM_REQ-1:0] grant_onehot;
    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    assign grant_onehot = NUM_REQ'(1) << grant_id_q;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;

    // While locked, only the owner of the lock (the last granted requester)
    // may compete.
    assign eligible = lock_q ? (req_valid & grant_onehot) : req_valid;
`else
    assign eligible = req_valid;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (eligible),
        .last_idx (grant_id_q),
        .winner   (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef UART_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        tx_start   = 1'b0;
        req_ready  = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Winner and its byte are captured here so both are already
                // valid on the outputs during the GRANT cycle.
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    tx_data_d  = req_data[pick_idx];
                    state_d    = ST_GRANT;
                end
            end

            ST_GRANT: begin
                tx_start   = 1'b1;
                req_ready  = grant_onehot;
                wait_cnt_d = '0;
`ifdef UART_ARB_LOCK_EN
                lock_d     = ~req_last[grant_id_q];
`endif
                state_d    = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_SEND;
                end else if (wait_cnt_q == 2'(WAIT_BUSY_LIMIT - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            ST_SEND: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_id_q <= ID_RESET;
            tx_data_q  <= '0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter at default parameters. Requesters
//   are byte queues, the transmitter is a behavioural busy-for-N-cycles model,
//   and expected grants come from a round-robin model over pending queues.
//   Build with +define+UART_ARB_LOCK_EN to exercise the lock feature.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR      = 4;
    localparam int GAP_CYC = 1 * (4_992_000 / 9600);
`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct packed {
        int            cyc;
        logic [NR-1:0] ready;
        byte_t         data;
        logic [1:0]    gid;
        int            since_busy;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_valid = '0;
    byte_t [NR-1:0] req_data = '0;
    logic [NR-1:0] req_last = '1;
    logic [NR-1:0] req_ready;
    logic          tx_start;
    byte_t         tx_data;
    logic          tx_busy = 1'b0;
    logic [1:0]    grant_id;

    uart_tx_arbiter #(
        .NUM_REQ  (NR),
        .CLK_FREQ (4_992_000),
        .BAUD     (9600),
        .GAP_BITS (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id)
    );

    always #5 clock = ~clock;

    // Stimulus state written by tasks only
    logic [7:0] rq [NR][$];
    bit         rl [NR][$];
    bit         force_all = 1'b1;
    bit         fault_mode = 1'b0;
    int         busy_len = 20;
    int         ev_rd = 0;

    // Environment state written by the negedge process only
    ev_t        ev_q [$];
    int         rd_ptr [NR];
    logic [NR-1:0] pop_pend = '0;
    int         cyc = 0;
    int         last_busy_cyc = 0;
    int         busy_left = 0;
    int         cur_len = 0;
    bit         start_seen = 1'b0;
    bit         prev_start = 1'b0;
    byte_t      held_data = '0;
    int         viol = 0;
    int         dviol = 0;

    // Reference model state
    int         m_cnt [NR];
    int         m_last = NR - 1;
    bit         m_lock = 1'b0;

    int         total = 0;
    int         bad = 0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            rd_ptr[i] = 0;
            m_cnt[i]  = 0;
        end
    end

    always @(negedge clock) begin
        ev_t ev;
        bit  pend;
        cyc++;
        // monitor
        if (req_ready != '0 && !tx_start) viol++;
        if (tx_start && !$onehot(req_ready)) viol++;
        if (tx_start && prev_start) viol++;
        if (tx_start) begin
            ev.cyc        = cyc;
            ev.ready      = req_ready;
            ev.data       = tx_data;
            ev.gid        = grant_id;
            ev.since_busy = cyc - last_busy_cyc;
            ev_q.push_back(ev);
            held_data = tx_data;
            cur_len   = busy_len;
        end else if (tx_busy && tx_data !== held_data) begin
            dviol++;
        end
        prev_start = tx_start;
        // transmitter: busy rises one cycle after tx_start for cur_len cycles
        if (reset || fault_mode) begin
            tx_busy   = 1'b0;
            busy_left = 0;
        end else if (tx_busy) begin
            if (busy_left <= 1) tx_busy = 1'b0;
            else busy_left--;
        end else if (start_seen) begin
            tx_busy   = 1'b1;
            busy_left = cur_len;
        end
        start_seen = tx_start && !reset;
        if (tx_busy) last_busy_cyc = cyc;
        // requesters: advance one cycle after the accept pulse
        for (int i = 0; i < NR; i++) begin
            if (pop_pend[i]) rd_ptr[i]++;
        end
        pop_pend = req_ready;
        for (int i = 0; i < NR; i++) begin
            pend         = rq[i].size() > rd_ptr[i];
            req_valid[i] = force_all | pend;
            req_data[i]  = pend ? rq[i][rd_ptr[i]] : 8'h00;
            req_last[i]  = pend ? rl[i][rd_ptr[i]] : 1'b1;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int model_pick();
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_last + k) % NR;
            if (rq[i].size() > m_cnt[i] && (!m_lock || i == m_last)) return i;
        end
        return -1;
    endfunction

    task automatic model_commit(input int id);
        m_lock = LOCK_EN && !rl[id][m_cnt[id]];
        m_cnt[id]++;
        m_last = id;
    endtask

    task automatic push_req(input int id, input logic [7:0] d, input bit last);
        rq[id].push_back(d);
        rl[id].push_back(last);
    endtask

    task automatic wait_grant(input int bound, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        for (int n = 0; n < bound && !ok; n++) begin
            @(posedge clock);
            #2;
            if (ev_q.size() > ev_rd) begin
                e = ev_q[ev_rd];
                ev_rd++;
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #2;
            total++;
            if (tx_start !== 1'b0) begin
                bad++;
                $display("FAIL reset_tx_start: got %b want 0", tx_start);
            end
            total++;
            if (req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL reset_req_ready: got %b want 0000", req_ready);
            end
        end
        total++;
        if (grant_id !== 2'd3) begin
            bad++;
            $display("FAIL reset_grant_id: got %0d want 3", grant_id);
        end
        total++;
        if (tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx_data: got %h want 00", tx_data);
        end
        force_all = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        total++;
        if (ev_q.size() !== ev_rd) begin
            bad++;
            $display("FAIL reset_no_grant: got %0d grants want 0", ev_q.size() - ev_rd);
        end
    endtask

    task automatic test_single();
        ev_t e;
        bit  ok;
        busy_len = 5200;
        push_req(2, 8'h5A, 1'b1);
        wait_grant(50, e, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_timeout: got no grant want grant within 50 cycles");
        end
        total++;
        if (e.ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready: got %b want 0100", e.ready);
        end
        total++;
        if (e.data !== 8'h5A) begin
            bad++;
            $display("FAIL single_data: got %h want 5a", e.data);
        end
        total++;
        if (e.gid !== 2'd2) begin
            bad++;
            $display("FAIL single_grant_id: got %0d want 2", e.gid);
        end
        model_commit(2);
        busy_len = 20;
        push_req(0, 8'(($urandom)), 1'b1);
        wait_grant(5200 + GAP_CYC + 100, e, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_next_timeout: got no grant want a grant after the gap");
        end
        total++;
        if (e.since_busy !== GAP_CYC + 3) begin
            bad++;
            $display("FAIL single_gap: got %0d want %0d", e.since_busy, GAP_CYC + 3);
        end
        total++;
        if (e.gid !== 2'(model_pick())) begin
            bad++;
            $display("FAIL single_next_id: got %0d want %0d", e.gid, model_pick());
        end
        model_commit(model_pick());
    endtask

    task automatic test_round_robin();
        ev_t e;
        bit  ok;
        int  exp;
        logic [NR-1:0] exp_ready;
        for (int i = 0; i < NR; i++) begin
            int n;
            n = 2 + int'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) push_req(i, 8'($urandom), 1'b1);
        end
        for (int g = 0; g < 16 && model_pick() >= 0; g++) begin
            exp       = model_pick();
            exp_ready = 4'(1) << exp;
            busy_len  = int'($urandom_range(1, 40));
            wait_grant(GAP_CYC + 200, e, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rr_timeout: got no grant want requester %0d", exp);
                break;
            end
            total++;
            if (e.gid !== 2'(exp)) begin
                bad++;
                $display("FAIL rr_grant_id: got %0d want %0d", e.gid, exp);
            end
            total++;
            if (e.ready !== exp_ready) begin
                bad++;
                $display("FAIL rr_ready: got %b want %b", e.ready, exp_ready);
            end
            total++;
            if (e.data !== rq[exp][m_cnt[exp]]) begin
                bad++;
                $display("FAIL rr_data: got %h want %h", e.data, rq[exp][m_cnt[exp]]);
            end
            total++;
            if (e.since_busy !== GAP_CYC + 3) begin
                bad++;
                $display("FAIL rr_gap: got %0d want %0d", e.since_busy, GAP_CYC + 3);
            end
            model_commit(exp);
        end
    endtask

    task automatic test_fault_escape();
        ev_t e1, e2;
        bit  ok;
        int  exp;
        fault_mode = 1'b1;
        push_req(1, 8'($urandom), 1'b1);
        push_req(3, 8'($urandom), 1'b1);
        exp = model_pick();
        wait_grant(GAP_CYC + 200, e1, ok);
        total++;
        if (!ok || e1.gid !== 2'(exp)) begin
            bad++;
            $display("FAIL fault_first: got ok=%0d id=%0d want id %0d", ok, e1.gid, exp);
        end
        model_commit(exp);
        exp = model_pick();
        wait_grant(GAP_CYC + 200, e2, ok);
        total++;
        if (!ok || e2.gid !== 2'(exp)) begin
            bad++;
            $display("FAIL fault_second: got ok=%0d id=%0d want id %0d", ok, e2.gid, exp);
        end
        model_commit(exp);
        total++;
        if (e2.cyc - e1.cyc !== GAP_CYC + 6) begin
            bad++;
            $display("FAIL fault_spacing: got %0d want %0d", e2.cyc - e1.cyc, GAP_CYC + 6);
        end
        fault_mode = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        ev_t e;
        bit  ok;
        busy_len = 200;
        push_req(1, 8'($urandom), 1'b1);
        wait_grant(GAP_CYC + 100, e, ok);
        total++;
        if (!ok || e.gid !== 2'd1) begin
            bad++;
            $display("FAIL rst_send_grant: got ok=%0d id=%0d want id 1", ok, e.gid);
        end
        model_commit(1);
        repeat (20) @(posedge clock);
        #2;
        push_req(0, 8'($urandom), 1'b1);
        push_req(1, 8'($urandom), 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset  = 1'b0;
        m_last = NR - 1;
        m_lock = 1'b0;
        total++;
        if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_send_quiet: got start=%b ready=%b want 0 0000", tx_start, req_ready);
        end
        total++;
        if (grant_id !== 2'd3) begin
            bad++;
            $display("FAIL rst_send_grant_id: got %0d want 3", grant_id);
        end
        wait_grant(20, e, ok);
        total++;
        if (!ok || e.gid !== 2'd0 || e.ready !== 4'b0001) begin
            bad++;
            $display("FAIL rst_send_after: got ok=%0d id=%0d ready=%b want id 0 ready 0001", ok, e.gid, e.ready);
        end
        model_commit(0);
        wait_grant(GAP_CYC + 300, e, ok);
        total++;
        if (!ok || e.gid !== 2'd1 || e.since_busy !== GAP_CYC + 3) begin
            bad++;
            $display("FAIL rst_send_next: got ok=%0d id=%0d gap=%0d want id 1 gap %0d", ok, e.gid, e.since_busy, GAP_CYC + 3);
        end
        model_commit(1);
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        ev_t e;
        bit  ok;
        int  want [4];
        want = '{1, 1, 1, 0};
        busy_len = 10;
        push_req(1, 8'($urandom), 1'b0);
        push_req(1, 8'($urandom), 1'b0);
        push_req(1, 8'($urandom), 1'b1);
        for (int g = 0; g < 4; g++) begin
            wait_grant(GAP_CYC + 200, e, ok);
            total++;
            if (!ok || e.gid !== 2'(want[g])) begin
                bad++;
                $display("FAIL lock_order[%0d]: got ok=%0d id=%0d want id %0d", g, ok, e.gid, want[g]);
            end
            if (ok) model_commit(int'(e.gid));
            if (g == 0) push_req(0, 8'($urandom), 1'b1);
        end
    endtask
`endif

    task automatic test_invariants();
        repeat (5) @(posedge clock);
        #2;
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL ready_start_protocol: got %0d violations want 0", viol);
        end
        total++;
        if (dviol !== 0) begin
            bad++;
            $display("FAIL tx_data_stable: got %0d changes want 0", dviol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fault_escape();
        test_reset_mid_send();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
